// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU request arbiter slice.
package alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_OPW   = 4;
  localparam int DEF_FLAGW = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_req_arbiter_mux.sv
// Plain 2-input mux; sel=1 picks d1.
module alu_req_arbiter_mux #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; issues a start
// pulse, waits for done or timeout, and returns the result via a response handshake.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int OPW     = DEF_OPW,
  parameter int FLAGW   = DEF_FLAGW,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [OPW-1:0]   r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [OPW-1:0]   r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             alu_start,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [FLAGW-1:0] alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [FLAGW-1:0] rsp_flags,
  output logic             rsp_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             prio;
  logic             gnt_id;
  logic             any_v;
  logic             accept;
  logic             id_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mux_a, mux_b;
  logic [OPW-1:0]   mux_op;

  assign any_v  = r0_valid | r1_valid;
  // Contention goes to prio; otherwise whichever is valid (r1 only if r0 idle).
  assign gnt_id = (r0_valid & r1_valid) ? prio : r1_valid;

  alu_req_arbiter_mux #(.WIDTH(WIDTH)) u_mux_a (
    .sel(gnt_id == REQ0), .d1(r0_a), .d0(r1_a), .y(mux_a));
  alu_req_arbiter_mux #(.WIDTH(WIDTH)) u_mux_b (
    .sel(gnt_id == REQ0), .d1(r0_b), .d0(r1_b), .y(mux_b));
  alu_req_arbiter_mux #(.WIDTH(OPW)) u_mux_op (
    .sel(gnt_id == REQ0), .d1(r0_op), .d0(r1_op), .y(mux_op));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    alu_start = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // Ready is gated by rst_n so every output reads 0 while reset is held.
        if (any_v && rst_n) begin
          r0_ready  = (gnt_id == REQ0);
          r1_ready  = (gnt_id == REQ1);
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        alu_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (alu_done || (cnt == CNT_LAST)) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= REQ0;
      id_q      <= REQ0;
      cnt       <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        alu_op <= mux_op;
        alu_a  <= mux_a;
        alu_b  <= mux_b;
        id_q   <= gnt_id;
      end
      case (state)
        ISSUE: cnt <= '0;
        WAIT: begin
          // done wins over a timeout landing in the same cycle
          if (alu_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= alu_result;
            rsp_flags <= alu_flags;
            rsp_err   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter against a transaction-level model of
// the round-robin grant, timeout and response rules.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 8, OPW = 4, FLAGW = 4, TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             r0_valid, r0_ready, r1_valid, r1_ready;
  logic [OPW-1:0]   r0_op, r1_op, alu_op;
  logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_result, rsp_data;
  logic             alu_start, alu_done, rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [FLAGW-1:0] alu_flags, rsp_flags;

  int n_chk = 0, n_pass = 0;
  int m_prio = 0;
  logic [OPW-1:0]   op_v[2];
  logic [WIDTH-1:0] a_v[2], b_v[2];

  alu_req_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .FLAGW(FLAGW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++) begin
      op_v[i] = OPW'($urandom);
      a_v[i]  = WIDTH'($urandom);
      b_v[i]  = WIDTH'($urandom);
    end
  endtask

  task automatic drive_req(input logic v0, input logic v1);
    r0_valid = v0; r0_op = op_v[0]; r0_a = a_v[0]; r0_b = b_v[0];
    r1_valid = v1; r1_op = op_v[1]; r1_a = a_v[1]; r1_b = b_v[1];
  endtask

  task automatic scramble_req();
    r0_valid = 1'b1; r0_op = OPW'($urandom); r0_a = WIDTH'($urandom); r0_b = WIDTH'($urandom);
    r1_valid = 1'b1; r1_op = OPW'($urandom); r1_a = WIDTH'($urandom); r1_b = WIDTH'($urandom);
  endtask

  // lat: WAIT cycle (1-based) carrying alu_done; 0 = never (timeout).
  task automatic txn(input logic v0, input logic v1, input int lat, input logic early,
                     input int hold, input logic [WIDTH-1:0] res, input logic [FLAGW-1:0] flg);
    int w;
    logic err_e;
    logic [WIDTH-1:0] data_e;
    logic [FLAGW-1:0] flg_e;
    w = (v0 && v1) ? m_prio : (v1 ? 1 : 0);
    err_e  = (lat < 1) || (lat > TIMEOUT);
    data_e = err_e ? '0 : res;
    flg_e  = err_e ? '0 : flg;
    drive_req(v0, v1);
    #1;
    chk("grant_r0_ready", r0_ready, w == 0);
    chk("grant_r1_ready", r1_ready, w == 1);
    step();
    scramble_req();
    #1;
    chk("issue_start", alu_start, 1'b1);
    chk("issue_op", alu_op, op_v[w]);
    chk("issue_a", alu_a, a_v[w]);
    chk("issue_b", alu_b, b_v[w]);
    chk("issue_ready", {r0_ready, r1_ready}, 2'b00);
    if (early) begin alu_done = 1'b1; alu_result = ~res; alu_flags = ~flg; end
    step();
    alu_done = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      chk("wait_no_rsp", {rsp_valid, alu_start}, 2'b00);
      if (i == lat) begin alu_done = 1'b1; alu_result = res; alu_flags = flg; end
      step();
      alu_done = 1'b0;
      if (i == lat) break;
    end
    for (int h = 0; h < hold; h++) begin
      scramble_req();
      alu_done = 1'($urandom);
      alu_result = WIDTH'($urandom);
      #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_fields", {rsp_id, rsp_err, rsp_flags, rsp_data}, {w[0], err_e, flg_e, data_e});
      chk("hold_quiet", {r0_ready, r1_ready, alu_start}, 3'b000);
      chk("hold_alu_a", alu_a, a_v[w]);
      step();
      alu_done = 1'b0;
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, w[0]);
    chk("rsp_data", rsp_data, data_e);
    chk("rsp_flags", rsp_flags, flg_e);
    chk("rsp_err", rsp_err, err_e);
    step();
    rsp_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    m_prio = 1 - w;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    alu_done = 1'b0; alu_result = '0; alu_flags = '0;
    rand_ops();
    drive_req(1'b0, 1'b0);
    #2;
    chk("rst_outputs", {alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err},
        '0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Move prio to 1, then reset mid-WAIT; prio must come back to 0.
    rand_ops();
    txn(1'b1, 1'b0, 2, 1'b0, 0, 8'h11, 4'h1);
    rand_ops();
    drive_req(1'b1, 1'b0);
    step(); step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wait", {alu_start, alu_op, alu_a, alu_b, rsp_valid, r0_ready, r1_ready}, '0);
    r0_valid = 1'b0;
    step();
    rst_n = 1'b1;
    m_prio = 0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_idle", {rsp_valid, alu_start}, 2'b00);
      step();
    end

    for (int i = 0; i < 6; i++) begin
      rand_ops();
      txn(1'b1, 1'b1, int'($urandom_range(1, 4)), 1'b0, 0, WIDTH'($urandom), FLAGW'($urandom));
    end

    rand_ops();
    op_v[0] = '0; a_v[0] = 8'h35; b_v[0] = 8'h0A;
    txn(1'b1, 1'b0, 2, 1'b0, 0, a_v[0] + b_v[0], 4'h0);
    chk("prio_after_r0", m_prio, 1);

    rand_ops();
    txn(1'b0, 1'b1, 0, 1'b0, 0, 8'hA5, 4'hF);
    rand_ops();
    txn(1'b1, 1'b1, 3, 1'b0, 5, 8'h5C, 4'h6);
    rand_ops();
    txn(1'b1, 1'b0, 3, 1'b1, 0, 8'h77, 4'h9);
    rand_ops();
    txn(1'b1, 1'b1, TIMEOUT, 1'b0, 1, 8'hC3, 4'h2);

    for (int i = 0; i < 20; i++) begin
      logic v0, v1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      rand_ops();
      txn(v0, v1, int'($urandom_range(0, TIMEOUT)), 1'($urandom), int'($urandom_range(0, 3)),
          WIDTH'($urandom), FLAGW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters (r0, r1) using round-robin arbitration.
- Accepts one request through a valid/ready handshake and captures its operands through a 2-input WIDTH-bit operand mux.
- Issues a start pulse to the ALU, waits for done or timeout, then returns the result to the winning requester through a response handshake.
- Sits between requester front-ends and the ALU core.

Parameters:
- WIDTH, 8, operand/result width in bits.
- OPW, 4, ALU opcode width.
- FLAGW, 4, ALU flag width (Z,N,C,V).
- TIMEOUT, 16, maximum cycles in WAIT before an error response; must be ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_valid  in  1  requester 0 has a request.
- r0_ready  out  1  request 0 accepted this cycle.
- r0_op  in  OPW  requester 0 opcode.
- r0_a  in  WIDTH  requester 0 operand A.
- r0_b  in  WIDTH  requester 0 operand B.
- r1_valid / r1_ready / r1_op / r1_a / r1_b  same as r0, for requester 1.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_op  out  OPW  registered opcode to the ALU.
- alu_a  out  WIDTH  registered operand A.
- alu_b  out  WIDTH  registered operand B.
- alu_done  in  1  ALU result valid (single-cycle pulse).
- alu_result  in  WIDTH  ALU result.
- alu_flags  in  FLAGW  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester owning the response (0/1).
- rsp_data  out  WIDTH  result.
- rsp_flags  out  FLAGW  flags.
- rsp_err  out  1  1 = ALU timeout; data/flags forced to 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; priority pointer prio=0 (r0 favoured).
  - All outputs 0. alu_op/a/b registers = 0. Timeout counter = 0.
  - Reset asserted in any state aborts the transaction. No response is issued for an in-flight request.
- IDLE:
  - Grant is combinational. If one valid is high, that requester wins. If both are high, the requester == prio wins.
  - Only the winner sees rX_ready=1; ready is 0 in all other states.
  - On the handshake (valid & ready):
    - Mux sel=1 selects r0 inputs, sel=0 selects r1; a/b/op are registered through the mux.
    - The grant id is latched; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE (1 cycle): alu_start=1, counter cleared, go to WAIT. An alu_done seen during ISSUE is ignored.
- WAIT:
  - alu_done=1: capture alu_result/alu_flags, rsp_err=0, go to RESP.
  - Otherwise increment the counter. When counter == TIMEOUT-1 and alu_done=0: rsp_err=1, data/flags=0, go to RESP.
  - If alu_done arrives in the same cycle as the timeout, done wins (err=0).
- RESP:
  - rsp_valid=1. rsp_id/data/flags/err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: prio = ~rsp_id, rsp_valid drops next cycle, go to IDLE.
  - alu_done in RESP is ignored.
- Throughput:
  - Minimum 4 cycles per transaction: accept, ISSUE, ≥1 WAIT, RESP with rsp_ready already high.
  - A new request can be accepted the cycle after the response handshake (rsp_valid already low).
- alu_op/a/b hold their captured values from acceptance until the next acceptance.
- Requester inputs are sampled only at their handshake. Later changes have no effect.

Decomposition:
- Shared package alu_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP), 2 bits.
  - OPW/FLAGW/WIDTH defaults.
  - requester id constants REQ0=0, REQ1=1.
- Sub-modules: the existing 2-input WIDTH-bit mux is instantiated twice (operands a, b), plus once with WIDTH=OPW for op.
- Arbitration, FSM, timeout counter and registers are inline.

Test Plan:
- Reset mid-WAIT: drop rst_n → all outputs 0 immediately. After release, state=IDLE, prio=0, no rsp_valid.
- r0 only, r0_a=8'h35, b=8'h0A, op=ADD; ALU returns done 2 cycles after start, result 8'h3F → alu_start one pulse 1 cycle after accept. rsp_valid, rsp_id=0, rsp_data=8'h3F, err=0. prio becomes 1.
- Both valid from reset → r0 granted first (r1_ready=0). r1 is granted on the next IDLE, then r0 again, giving strict alternation over 6 back-to-back requests.
- alu_done never asserted, TIMEOUT=16 → rsp_valid with rsp_err=1, data=0, exactly 16 cycles after the ISSUE cycle.
- rsp_ready held low for 5 cycles while requester inputs toggle → rsp fields stable, r0_ready/r1_ready stay 0, no new alu_start.
- alu_done pulsed during ISSUE then again in WAIT → only the WAIT pulse's result is reported. alu_done coinciding with the timeout cycle → err=0, result reported.
